// File: rtl/bnn_pkg.sv
// Shared definitions for the binary-MAC loader: default geometry,
// packed word width and the loader FSM state encoding.
package bnn_pkg;

    localparam int ELEM_W_DEF = 7;
    localparam int LANES_DEF  = 8;
    localparam int ADDR_W_DEF = 8;
    localparam int WORD_W     = ELEM_W_DEF * LANES_DEF;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FILL  = 3'd1,
        FLUSH = 3'd2,
        WAIT  = 3'd3,
        RUN   = 3'd4,
        DRAIN = 3'd5
    } state_t;

endpackage

// File: rtl/bnn_run_seq.sv
// Replay sequencer for the popcount engine. A start pulse latches the word
// count N. The run then steps through phases 0..N+3: phase 0 clears the
// accumulator, phases 1..N drive read addresses 0..N-1, phases 2..N+1
// enable accumulation (one cycle of SRAM read latency), phase N+2 drains and
// phase N+3 pulses done. last_run flags the final RUN phase (N+1) so the
// parent FSM can step into DRAIN on the right edge.
module bnn_run_seq
    import bnn_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W:0]   n,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              acc_en,
    output logic              acc_clr,
    output logic              done,
    output logic              last_run
);

    localparam int PH_W = ADDR_W + 2;

    logic              active_r;
    logic [ADDR_W:0]   n_r;
    logic [PH_W-1:0]   phase_r;
    logic [PH_W-1:0]   phase_nxt_s;
    logic [PH_W-1:0]   n_ext_s;
    logic [ADDR_W-1:0] rd_addr_r;
    logic              acc_en_r;
    logic              acc_clr_r;
    logic              done_r;

    // Next phase and detection of the last RUN phase
    always_comb begin
        n_ext_s     = {1'b0, n_r};
        phase_nxt_s = phase_r + PH_W'(1);
        last_run    = active_r && (phase_r == (n_ext_s + PH_W'(1)));
    end

    // Phase counter and registered engine controls
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            active_r  <= 1'b0;
            n_r       <= '0;
            phase_r   <= '0;
            rd_addr_r <= '0;
            acc_en_r  <= 1'b0;
            acc_clr_r <= 1'b0;
            done_r    <= 1'b0;
        end else if (start) begin
            active_r  <= 1'b1;
            n_r       <= n;
            phase_r   <= '0;
            acc_en_r  <= 1'b0;
            acc_clr_r <= 1'b1;
            done_r    <= 1'b0;
        end else if (active_r) begin
            phase_r   <= phase_nxt_s;
            acc_clr_r <= 1'b0;
            if ((phase_nxt_s >= PH_W'(1)) && (phase_nxt_s <= n_ext_s)) begin
                rd_addr_r <= ADDR_W'(phase_nxt_s - PH_W'(1));
            end
            acc_en_r <= (phase_nxt_s >= PH_W'(2)) && (phase_nxt_s <= (n_ext_s + PH_W'(1)));
            done_r   <= (phase_nxt_s == (n_ext_s + PH_W'(3)));
            if (phase_nxt_s == (n_ext_s + PH_W'(3))) begin
                active_r <= 1'b0;
            end
        end else begin
            acc_en_r  <= 1'b0;
            acc_clr_r <= 1'b0;
            done_r    <= 1'b0;
        end
    end

    assign rd_addr = rd_addr_r;
    assign acc_en  = acc_en_r;
    assign acc_clr = acc_clr_r;
    assign done    = done_r;

endmodule

// File: rtl/bnn_loader.sv
// Stream-to-SRAM packer and compute sequencer for the binary-MAC datapath.
// Packs LANES elements per SRAM word (last lane is the weight), writes
// words at incrementing addresses, then replays the frame through the read
// port via bnn_run_seq.
// Build option: BNN_LOADER_AUTORUN_EN - when defined, a closed frame starts
// the run immediately and `start` is ignored; otherwise the block parks in
// WAIT until a `start` pulse.
module bnn_loader
    import bnn_pkg::*;
#(
    parameter int ELEM_W = ELEM_W_DEF,
    parameter int LANES  = LANES_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      s_valid,
    input  logic [ELEM_W-1:0]         s_data,
    input  logic                      s_last,
    output logic                      s_ready,
    input  logic                      start,
    output logic                      we,
    output logic [ADDR_W-1:0]         addr_w,
    output logic [ELEM_W*LANES-1:0]   data_w,
    output logic [ADDR_W-1:0]         addr_r,
    output logic                      w_en,
    output logic                      c_rst,
    output logic                      busy,
    output logic                      done,
    output logic [ADDR_W:0]           words,
    output logic                      ovf
);

    localparam int DATA_W = ELEM_W * LANES;
    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int CNT_W  = ADDR_W + 1;

`ifdef BNN_LOADER_AUTORUN_EN
    localparam state_t LOADED_ST = RUN;
`else
    localparam state_t LOADED_ST = WAIT;
`endif

    state_t            state_r;
    state_t            state_nxt_s;
    logic              s_ready_r;
    logic              busy_r;
    logic              we_r;
    logic [ADDR_W-1:0] addr_w_r;
    logic [DATA_W-1:0] data_w_r;
    logic [CNT_W-1:0]  words_r;
    logic              ovf_r;
    logic [LANE_W-1:0] lane_r;
    logic [DATA_W-1:0] stage_r;
    logic [ADDR_W-1:0] wptr_r;

    logic              hs_s;
    logic [LANE_W-1:0] lane_sel_s;
    logic [ADDR_W-1:0] wptr_sel_s;
    logic [CNT_W-1:0]  words_base_s;
    logic [CNT_W-1:0]  words_nxt_s;
    logic              ovf_base_s;
    logic [DATA_W-1:0] word_s;
    logic              lane_full_s;
    logic              at_top_s;
    logic              close_s;
    logic              hit_top_s;
    logic              frame_end_s;
    logic              run_start_s;
    logic              last_run_s;

    // Handshake decode; the first element of a frame starts from a clean slate
    always_comb begin
        hs_s = s_valid && s_ready_r;
        if (state_r == IDLE) begin
            lane_sel_s   = '0;
            wptr_sel_s   = '0;
            words_base_s = '0;
            ovf_base_s   = 1'b0;
            word_s       = '0;
        end else begin
            lane_sel_s   = lane_r;
            wptr_sel_s   = wptr_r;
            words_base_s = words_r;
            ovf_base_s   = ovf_r;
            word_s       = stage_r;
        end
        word_s[ELEM_W*lane_sel_s +: ELEM_W] = s_data;
        lane_full_s = (lane_sel_s == LANE_W'(LANES - 1));
        at_top_s    = (wptr_sel_s == {ADDR_W{1'b1}});
        close_s     = hs_s && (lane_full_s || s_last);
        hit_top_s   = hs_s && lane_full_s && at_top_s && !s_last;
        frame_end_s = (hs_s && s_last) || hit_top_s;
        if (close_s) begin
            words_nxt_s = words_base_s + CNT_W'(1);
        end else begin
            words_nxt_s = words_r;
        end
    end

    // Loader FSM next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE, FILL: begin
                if (frame_end_s) begin
                    state_nxt_s = lane_full_s ? LOADED_ST : FLUSH;
                end else if (hs_s) begin
                    state_nxt_s = FILL;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            FLUSH: state_nxt_s = LOADED_ST;
`ifdef BNN_LOADER_AUTORUN_EN
            WAIT:  state_nxt_s = IDLE;
`else
            WAIT: begin
                if (start) begin
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = WAIT;
                end
            end
`endif
            RUN: begin
                if (last_run_s) begin
                    state_nxt_s = DRAIN;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            DRAIN:   state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
        run_start_s = (state_nxt_s == RUN) && (state_r != RUN);
    end

    // State register and the flags that follow directly from the next state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= IDLE;
            s_ready_r <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            s_ready_r <= (state_nxt_s == IDLE) || (state_nxt_s == FILL);
            busy_r    <= (state_nxt_s != IDLE);
        end
    end

    // Lane packing, write port and frame bookkeeping
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we_r     <= 1'b0;
            addr_w_r <= '0;
            data_w_r <= '0;
            words_r  <= '0;
            ovf_r    <= 1'b0;
            lane_r   <= '0;
            stage_r  <= '0;
            wptr_r   <= '0;
        end else begin
            we_r <= close_s;
            if (close_s) begin
                addr_w_r <= wptr_sel_s;
                data_w_r <= word_s;
                stage_r  <= '0;
                lane_r   <= '0;
                wptr_r   <= at_top_s ? wptr_sel_s : (wptr_sel_s + ADDR_W'(1));
                words_r  <= words_nxt_s;
                ovf_r    <= ovf_base_s || hit_top_s;
            end else if (hs_s) begin
                stage_r  <= word_s;
                lane_r   <= lane_sel_s + LANE_W'(1);
                wptr_r   <= wptr_sel_s;
                words_r  <= words_base_s;
                ovf_r    <= ovf_base_s;
            end
        end
    end

    bnn_run_seq #(
        .ADDR_W (ADDR_W)
    ) u_run_seq (
        .clk      (clk),
        .rst      (rst),
        .start    (run_start_s),
        .n        (words_nxt_s),
        .rd_addr  (addr_r),
        .acc_en   (w_en),
        .acc_clr  (c_rst),
        .done     (done),
        .last_run (last_run_s)
    );

    assign s_ready = s_ready_r;
    assign busy    = busy_r;
    assign we      = we_r;
    assign addr_w  = addr_w_r;
    assign data_w  = data_w_r;
    assign words   = words_r;
    assign ovf     = ovf_r;

endmodule

// File: tb/tb_bnn_loader.sv
// Directed self-checking bench for bnn_loader (default geometry 7x8, 256 words).
// Works with and without BNN_LOADER_AUTORUN_EN.
module tb_bnn_loader;

    logic        clk;
    logic        rst;
    logic        s_valid;
    logic [6:0]  s_data;
    logic        s_last;
    logic        s_ready;
    logic        start;
    logic        we;
    logic [7:0]  addr_w;
    logic [55:0] data_w;
    logic [7:0]  addr_r;
    logic        w_en;
    logic        c_rst;
    logic        busy;
    logic        done;
    logic [8:0]  words;
    logic        ovf;

    int checks   = 0;
    int failures = 0;

    int          cyc       = 0;
    int          wr_cnt    = 0;
    int          crst_cnt  = 0;
    int          wen_cnt   = 0;
    int          done_cnt  = 0;
    int          crst_cyc  = -1;
    int          done_cyc  = -1;
    int          start_cyc = -1;
    logic [7:0]  last_wa   = 8'd0;
    logic        we_rdy    = 1'b0;
    logic [55:0] mem [0:255];
    logic [7:0]  ar_log [0:299];
    logic        wen_log [0:299];

    bnn_loader dut (
        .clk     (clk),
        .rst     (rst),
        .s_valid (s_valid),
        .s_data  (s_data),
        .s_last  (s_last),
        .s_ready (s_ready),
        .start   (start),
        .we      (we),
        .addr_w  (addr_w),
        .data_w  (data_w),
        .addr_r  (addr_r),
        .w_en    (w_en),
        .c_rst   (c_rst),
        .busy    (busy),
        .done    (done),
        .words   (words),
        .ovf     (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observe the DUT away from the active edge and log port activity
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (start) start_cyc = cyc;
        if (we) begin
            mem[addr_w] = data_w;
            wr_cnt      = wr_cnt + 1;
            last_wa     = addr_w;
            we_rdy      = s_ready;
        end
        if (c_rst) begin
            crst_cnt = crst_cnt + 1;
            crst_cyc = cyc;
        end
        if (w_en) wen_cnt = wen_cnt + 1;
        if (done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
        if (crst_cyc >= 0 && (cyc - crst_cyc) < 300) begin
            ar_log[cyc - crst_cyc]  = addr_r;
            wen_log[cyc - crst_cyc] = w_en;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [55:0] pack_seq(input int first, input int cnt);
        logic [55:0] w;
        w = 56'd0;
        for (int k = 0; k < cnt; k++) w[7*k +: 7] = 7'(first + k);
        return w;
    endfunction

    task automatic clear_logs();
        wr_cnt = 0; crst_cnt = 0; wen_cnt = 0; done_cnt = 0;
        crst_cyc = -1; done_cyc = -1; start_cyc = -1;
        for (int i = 0; i < 300; i++) begin
            ar_log[i]  = 8'd0;
            wen_log[i] = 1'b0;
        end
    endtask

    task automatic idle_cycle();
        s_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    // Offer one element; gives up after a bounded number of cycles
    task automatic send_elem(input logic [6:0] d, input logic last, output bit ok);
        bit acc;
        acc     = 1'b0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        for (int t = 0; t < 40 && !acc; t++) begin
            acc = s_ready;
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        ok      = acc;
    endtask

    task automatic load_frame(input int n, input bit last_final, output int acc);
        bit ok;
        acc = 0;
        for (int i = 1; i <= n; i++) begin
            send_elem(7'(i), last_final && (i == n), ok);
            if (ok) acc = acc + 1;
        end
    endtask

    task automatic kick(input int delay);
        repeat (delay) begin @(posedge clk); #1; end
`ifndef BNN_LOADER_AUTORUN_EN
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
`endif
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int t = 0; t < budget && !ok; t++) begin
            if (done_cnt > 0) ok = 1'b1;
            else begin @(posedge clk); #1; end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        bit ok;
        rst = 1'b0; s_valid = 1'b0; s_data = 7'd0; s_last = 1'b0; start = 1'b0;
        clear_logs();

        // Reset values
        repeat (2) @(posedge clk); #1;
        check("rst_ctrl", 64'({we, addr_w, w_en, c_rst, busy, done, ovf, s_ready, addr_r, words}), 64'd0);
        check("rst_data_w", 64'(data_w), 64'd0);
        #3 rst = 1'b1;
        @(posedge clk); #1;
        check("rst_ready_rise", 64'(s_ready), 64'd1);

        // T1: 16 elements, last on lane 7
        clear_logs();
        load_frame(16, 1'b1, acc);
        kick(3);
        wait_done(100, ok);
        check("t1_done_seen", 64'(ok), 64'd1);
        check("t1_accepted", 64'(acc), 64'd16);
        check("t1_writes", 64'(wr_cnt), 64'd2);
        check("t1_word0", 64'(mem[0]), 64'(pack_seq(1, 8)));
        check("t1_word1", 64'(mem[1]), 64'(pack_seq(9, 8)));
        check("t1_lane0_w1", 64'(mem[1][6:0]), 64'd9);
        check("t1_words", 64'(words), 64'd2);
        check("t1_crst_cnt", 64'(crst_cnt), 64'd1);
        check("t1_addr_r1", 64'(ar_log[1]), 64'd0);
        check("t1_addr_r2", 64'(ar_log[2]), 64'd1);
        check("t1_wen_win", 64'({wen_log[1], wen_log[2], wen_log[3], wen_log[4]}), 64'b0110);
        check("t1_wen_cnt", 64'(wen_cnt), 64'd2);
        check("t1_done_ofs", 64'(done_cyc - crst_cyc), 64'd5);
        check("t1_idle", 64'({busy, s_ready}), 64'b01);

        // T2: 11 elements, partial last word goes through FLUSH
        clear_logs();
        load_frame(11, 1'b1, acc);
        kick(3);
        wait_done(100, ok);
        check("t2_done_seen", 64'(ok), 64'd1);
        check("t2_writes", 64'(wr_cnt), 64'd2);
        check("t2_word1", 64'(mem[1]), 64'(pack_seq(9, 3)));
        check("t2_flush_ready", 64'(we_rdy), 64'd0);
        check("t2_words", 64'(words), 64'd2);
        check("t2_done_ofs", 64'(done_cyc - crst_cyc), 64'd5);

        // T3: valid toggled every other cycle
        clear_logs();
        acc = 0;
        for (int i = 1; i <= 16; i++) begin
            send_elem(7'(i), (i == 16), ok);
            if (ok) acc = acc + 1;
            idle_cycle();
            if (i == 7) check("t3_no_early_we", 64'(wr_cnt), 64'd0);
            if (i == 8) check("t3_we_after_l7", 64'(wr_cnt), 64'd1);
        end
        kick(3);
        wait_done(100, ok);
        check("t3_done_seen", 64'(ok), 64'd1);
        check("t3_accepted", 64'(acc), 64'd16);
        check("t3_word0", 64'(mem[0]), 64'(pack_seq(1, 8)));
        check("t3_word1", 64'(mem[1]), 64'(pack_seq(9, 8)));

        // T4: 2049 elements without last -> overflow at the top address
        clear_logs();
        load_frame(2049, 1'b0, acc);
        check("t4_accepted", 64'(acc), 64'd2048);
        check("t4_writes", 64'(wr_cnt), 64'd256);
        check("t4_last_addr", 64'(last_wa), 64'd255);
        check("t4_ovf", 64'(ovf), 64'd1);
        check("t4_words", 64'(words), 64'd256);
        check("t4_ready_low", 64'(s_ready), 64'd0);
        check("t4_word0", 64'(mem[0]), 64'(pack_seq(1, 8)));
        check("t4_word255", 64'(mem[255]), 64'(pack_seq(2041, 8)));
        kick(3);
        wait_done(600, ok);
        check("t4_done_seen", 64'(ok), 64'd1);
        check("t4_wen_cnt", 64'(wen_cnt), 64'd256);
        check("t4_addr_r_last", 64'(ar_log[256]), 64'd255);
        check("t4_done_ofs", 64'(done_cyc - crst_cyc), 64'd259);

        // T5: short frame; delayed start holds the block in WAIT
        clear_logs();
        load_frame(3, 1'b1, acc);
        check("t5_ovf_cleared", 64'(ovf), 64'd0);
`ifndef BNN_LOADER_AUTORUN_EN
        repeat (10) begin @(posedge clk); #1; end
        check("t5_wait_busy", 64'(busy), 64'd1);
        check("t5_wait_quiet", 64'({we, w_en, c_rst, done, s_ready}), 64'd0);
        kick(0);
`endif
        wait_done(100, ok);
        check("t5_done_seen", 64'(ok), 64'd1);
`ifndef BNN_LOADER_AUTORUN_EN
        check("t5_crst_after_start", 64'(crst_cyc - start_cyc), 64'd1);
`endif
        check("t5_words", 64'(words), 64'd1);
        check("t5_word0", 64'(mem[0]), 64'(pack_seq(1, 3)));
        check("t5_done_ofs", 64'(done_cyc - crst_cyc), 64'd4);

        // T6: reset asserted during R3 of an N=3 run
        clear_logs();
        load_frame(24, 1'b1, acc);
        kick(3);
        ok = 1'b0;
        for (int t = 0; t < 50 && !ok; t++) begin
            if (c_rst) ok = 1'b1;
            else begin @(posedge clk); #1; end
        end
        check("t6_r0_seen", 64'(ok), 64'd1);
        repeat (3) begin @(posedge clk); #1; end
        check("t6_r3_addr", 64'(addr_r), 64'd2);
        check("t6_r3_wen", 64'(w_en), 64'd1);
        #2 rst = 1'b0;
        #1;
        check("t6_async_ctrl", 64'({we, addr_w, w_en, c_rst, busy, done, ovf, s_ready, addr_r, words}), 64'd0);
        check("t6_async_data", 64'(data_w), 64'd0);
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        @(posedge clk); #1;
        check("t6_ready_rise", 64'(s_ready), 64'd1);
        repeat (10) idle_cycle();
        check("t6_no_done", 64'(done_cnt), 64'd0);
        clear_logs();
        load_frame(8, 1'b1, acc);
        kick(3);
        wait_done(100, ok);
        check("t6_done_seen", 64'(ok), 64'd1);
        check("t6_restart_addr", 64'(last_wa), 64'd0);
        check("t6_restart_wr", 64'(wr_cnt), 64'd1);
        check("t6_restart_word", 64'(mem[0]), 64'(pack_seq(1, 8)));
        check("t6_words", 64'(words), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
